// File: rtl/div_stall_unit.sv
// Radix-2 restoring divider (DIV/DIVU) for EX. Latency: WIDTH+1 cycles; 2 cycles for divide-by-zero.
// Holds the pipeline via combinational stallreq_for_ex until the result is ready; annul_i aborts at once.
// Optional macro DIV_EARLY_EXIT_EN: finishes in 1 cycle when |dividend| < |divisor|.
module div_stall_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start_i,
    input  logic               div_signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               annul_i,
    output logic               stallreq_for_ex,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   dvd_abs, dvs_abs;
    logic               start_ok;
    logic               last_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_sub, rem_next, quo_next;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               q_bit;
    logic               early_exit;

    // Operand magnitudes and one restoring step; the dividend register doubles as the quotient shifter.
    always_comb begin
        dvd_abs    = (div_signed_i && dividend_i[WIDTH-1]) ? (~dividend_i + WIDTH'(1)) : dividend_i;
        dvs_abs    = (div_signed_i && divisor_i[WIDTH-1])  ? (~divisor_i  + WIDTH'(1)) : divisor_i;
        start_ok   = div_start_i & ~annul_i;
        last_step  = (cnt_q == CW'(WIDTH - 1));
        rem_shift  = {rem_q, dvd_q[WIDTH-1]};
        q_bit      = (rem_shift >= {1'b0, dvs_q});
        rem_sub    = rem_shift[WIDTH-1:0] - dvs_q;
        rem_next   = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
        quo_next   = {dvd_q[WIDTH-2:0], q_bit};
        quo_fix    = neg_quo_q ? (~quo_next + WIDTH'(1)) : quo_next;
        rem_fix    = neg_rem_q ? (~rem_next + WIDTH'(1)) : rem_next;
`ifdef DIV_EARLY_EXIT_EN
        early_exit = (divisor_i != '0) && (dvd_abs < dvs_abs);
`else
        early_exit = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (annul_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        if (divisor_i == '0) begin
                            state_d = S_DIVZERO;
                        end else if (early_exit) begin
                            state_d = S_END;
                        end else begin
                            state_d = S_ON;
                        end
                    end
                end
                S_DIVZERO: state_d = S_END;
                S_ON:      state_d = last_step ? S_END : S_ON;
                S_END:     state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Output logic; reset also drops the request so the pipeline is released immediately.
    always_comb begin
        stallreq_for_ex = rst & div_start_i & ~annul_i & (state_q != S_END);
        ready_o         = ready_q;
        result_o        = result_q;
    end

    // Datapath next values
    always_comb begin
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = 1'b0;
        if (!annul_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        cnt_d     = '0;
                        rem_d     = '0;
                        dvs_d     = dvs_abs;
                        neg_quo_d = div_signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        neg_rem_d = div_signed_i & dividend_i[WIDTH-1];
                        // Divide-by-zero reports the raw dividend, so keep it unmodified.
                        dvd_d     = (divisor_i == '0) ? dividend_i : dvd_abs;
                        if (early_exit) begin
                            result_d = {dividend_i, {WIDTH{1'b0}}};
                            ready_d  = 1'b1;
                        end
                    end
                end
                S_DIVZERO: begin
                    result_d = {dvd_q, {WIDTH{1'b1}}};
                    ready_d  = 1'b1;
                end
                S_ON: begin
                    dvd_d = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_step) begin
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed bench for div_stall_unit: stall/ready timing, signed fix-up, divide-by-zero, annul, reset.
module tb_div_stall_unit;

    logic        clk;
    logic        rst;
    logic        div_start_i;
    logic        div_signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic        stallreq_for_ex;
    logic        ready_o;
    logic [63:0] result_o;

    int checks = 0;
    int errors = 0;

    div_stall_unit #(.WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .div_start_i     (div_start_i),
        .div_signed_i    (div_signed_i),
        .dividend_i      (dividend_i),
        .divisor_i       (divisor_i),
        .annul_i         (annul_i),
        .stallreq_for_ex (stallreq_for_ex),
        .ready_o         (ready_o),
        .result_o        (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the sampling point (falling edge) of the next cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        div_start_i  = 1'b1;
        div_signed_i = sgn;
        dividend_i   = a;
        divisor_i    = b;
        #1;
    endtask

    // Called in the accepting cycle T0; ends in the cycle where ready_o is expected.
    task automatic expect_div(input int lat, input logic [63:0] res, input string tag);
        chk({tag, " stall_t0"}, 64'(stallreq_for_ex), 64'd1);
        chk({tag, " ready_t0"}, 64'(ready_o), 64'd0);
        for (int k = 1; k < lat; k++) begin
            step();
            chk($sformatf("%s stall_t%0d", tag, k), 64'(stallreq_for_ex), 64'd1);
            chk($sformatf("%s ready_t%0d", tag, k), 64'(ready_o), 64'd0);
        end
        step();
        chk({tag, " ready"}, 64'(ready_o), 64'd1);
        chk({tag, " stall_end"}, 64'(stallreq_for_ex), 64'd0);
        chk({tag, " result"}, result_o, res);
    endtask

    task automatic release_ex(input string tag);
        div_start_i = 1'b0;
        step();
        chk({tag, " ready_pulse"}, 64'(ready_o), 64'd0);
    endtask

    initial begin
        rst          = 1'b0;
        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        dividend_i   = 32'd0;
        divisor_i    = 32'd0;
        annul_i      = 1'b0;
        @(negedge clk);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        chk("reset stall", 64'(stallreq_for_ex), 64'd0);
        div_start_i = 1'b0;
        rst = 1'b1;
        step();

        // 1: DIVU 100/7
        issue(1'b0, 32'd100, 32'd7);
        expect_div(33, {32'd2, 32'd14}, "divu_100_7");
        release_ex("divu_100_7");

        // 2: signed cases, including the overflowing one
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        expect_div(33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
        release_ex("div_m7_2");
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_div(33, {32'h0000_0000, 32'h8000_0000}, "div_min_m1");
        release_ex("div_min_m1");

        // 3: divide by zero
        issue(1'b0, 32'h0000_1234, 32'd0);
        expect_div(2, {32'h0000_1234, 32'hFFFF_FFFF}, "divu_by0");
        release_ex("divu_by0");

        // 4: annul mid-operation
        issue(1'b0, 32'd100, 32'd7);
        for (int k = 0; k < 10; k++) step();
        annul_i = 1'b1;
        #1;
        chk("annul stall", 64'(stallreq_for_ex), 64'd0);
        step();
        annul_i     = 1'b0;
        div_start_i = 1'b0;
        #1;
        chk("annul stall_after", 64'(stallreq_for_ex), 64'd0);
        chk("annul result_kept", result_o, {32'h0000_1234, 32'hFFFF_FFFF});
        for (int k = 0; k < 30; k++) begin
            chk($sformatf("annul no_ready_%0d", k), 64'(ready_o), 64'd0);
            step();
        end
        issue(1'b0, 32'd9, 32'd3);
        expect_div(33, {32'd0, 32'd3}, "divu_9_3");
        release_ex("divu_9_3");

        // 5: back-to-back with start held; second T0 is one cycle after the first END
        issue(1'b0, 32'd50, 32'd5);
        expect_div(33, {32'd0, 32'd10}, "b2b_50_5");
        issue(1'b0, 32'd7, 32'd7);
        step();
        expect_div(33, {32'd0, 32'd1}, "b2b_7_7");
        release_ex("b2b_7_7");

        // 6: asynchronous reset mid-operation, then small quotient case
        issue(1'b0, 32'd100, 32'd7);
        for (int k = 0; k < 5; k++) step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst ready", 64'(ready_o), 64'd0);
        chk("arst stall", 64'(stallreq_for_ex), 64'd0);
        chk("arst result", result_o, 64'd0);
        div_start_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        issue(1'b0, 32'd3, 32'd10);
`ifdef DIV_EARLY_EXIT_EN
        expect_div(1, {32'd3, 32'd0}, "divu_3_10");
`else
        expect_div(33, {32'd3, 32'd0}, "divu_3_10");
`endif
        release_ex("divu_3_10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_stall_unit.md
Name: div_stall_unit

Overview:
- Iterative 32-cycle radix-2 divider in the EX stage; executes DIV/DIVU.
- It is the requesting end of the pipeline stall interface: it drives stallreq_for_ex to the stall controller, which freezes IF..EX until the quotient and remainder are ready.
- Results go to the HI/LO write path: HI = remainder, LO = quotient.

Parameters:
WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
div_start_i  input  1  EX holds a DIV/DIVU; held stable by the stall while busy
div_signed_i  input  1  1 = DIV (signed), 0 = DIVU
dividend_i  input  WIDTH  rs operand
divisor_i  input  WIDTH  rt operand
annul_i  input  1  flush/cancel of the EX instruction
stallreq_for_ex  output  1  stall request to the controller (combinational)
ready_o  output  1  one-cycle pulse: result_o valid
result_o  output  2*WIDTH  {remainder, quotient}

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, ready_o=0, result_o=0, internal regs=0. Takes effect immediately, including mid-operation.
- States: IDLE, DIVZERO, ON, END.
- IDLE, div_start_i=1, annul_i=0:
  - Latch |dividend| and |divisor| (absolute values only when div_signed_i=1) plus the sign flags.
  - Next state is DIVZERO if divisor_i==0, otherwise ON with cnt=0.
- ON: one restoring shift-subtract step per cycle, using a (WIDTH+1)-bit partial remainder and a compare/subtract.
  - After WIDTH steps (cnt==WIDTH-1), apply signs and register result_o, set ready_o=1, go to END.
- Sign fix-up:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - All arithmetic truncates to WIDTH, so 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0.
- DIVZERO: register quotient=all ones, remainder=dividend_i (raw), set ready_o=1, go to END.
- END: ready_o=1 for exactly this cycle; next state IDLE unconditionally; ready_o returns to 0.
- result_o holds its last value until the next result is registered.
- stallreq_for_ex = div_start_i & ~annul_i & (state != END).
  - Asserted in the accepting IDLE cycle and in every DIVZERO/ON cycle.
  - Deasserted in the END cycle, so EX advances with the result.
  - A back-to-back DIV entering EX after END sees IDLE and starts a new operation.
- Latency, start accepted at T0:
  - Normal: ready_o at T0+WIDTH+1 (T0+33); stallreq high T0..T0+32.
  - Divide by zero: ready_o at T0+2; stallreq high T0..T0+1.
- annul_i=1 in any state:
  - stallreq_for_ex=0 in the same cycle.
  - Next state IDLE, ready_o=0 next cycle, result_o unchanged.
  - Annul and start together in IDLE: annul wins, stay IDLE.
- div_start_i dropping while ON (not expected under stall) is ignored; the operation completes.
- Operand inputs are ignored after acceptance.

Optional Feature:
DIV_EARLY_EXIT_EN:
- Defined: in IDLE with start, if divisor != 0 and |dividend| < |divisor| (unsigned compare of the latched magnitudes' inputs), go directly to END.
  - Register quotient=0, remainder=dividend_i (raw), ready_o=1 at T0+1, stallreq high at T0 only.
- Undefined: such operands take the full WIDTH-step path; results are identical.

Test Plan:
1. DIVU 100/7 held under stall -> stallreq_for_ex=1 for T0..T0+32; ready_o pulses at T0+33; result_o={32'd2, 32'd14}.
2. DIV 0xFFFFFFF9 (-7) / 2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD}; DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
3. DIVU 0x1234 / 0 -> ready_o at T0+2; result_o={0x00001234, 0xFFFFFFFF}; stallreq high 2 cycles.
4. annul_i=1 at T0+10 -> stallreq_for_ex=0 that cycle; IDLE next cycle; no ready_o pulse; a new DIVU 9/3 afterwards -> {0, 3} at its T0+33.
5. Back-to-back DIVU 50/5 then DIVU 7/7 with start held high -> two ready_o pulses 34 cycles apart; results {0, 10} then {0, 1}.
6. rst=0 at T0+5 of a DIVU -> ready_o, stallreq_for_ex, result_o go to 0 without a clock edge. DIVU 3/10 -> {3, 0}: at T0+1 with DIV_EARLY_EXIT_EN, at T0+33 without.
